// File: rtl/tdc_pkg.sv
// Shared constants for the TDC thermometer decoder: FSM encodings, default
// delay-line width and the code-width helper.
package tdc_pkg;

  localparam int unsigned TDC_N_DELAY = 32;
  localparam int unsigned TDC_STATE_W = 3;

  localparam logic [TDC_STATE_W-1:0] TDC_IDLE   = 3'd0;
  localparam logic [TDC_STATE_W-1:0] TDC_SAMPLE = 3'd1;
  localparam logic [TDC_STATE_W-1:0] TDC_DECODE = 3'd2;
  localparam logic [TDC_STATE_W-1:0] TDC_ACCUM  = 3'd3;
  localparam logic [TDC_STATE_W-1:0] TDC_HOLD   = 3'd4;

  // Bits needed to hold any code 0..n.
  function automatic int unsigned tdc_code_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/tdc_therm2bin.sv
// Combinational thermometer-to-binary converter: 3-tap majority bubble fix,
// popcount, and saturation detect (all taps set).
module tdc_therm2bin
  import tdc_pkg::*;
#(
  parameter int unsigned N_DELAY = TDC_N_DELAY,
  parameter int unsigned CODE_W  = tdc_code_w(N_DELAY)
) (
  input  logic [N_DELAY-1:0] therm_i,
  output logic [CODE_W-1:0]  code_c,
  output logic               sat_c
);

  // Padded line: tap below bit 0 reads 1, tap above the top bit reads 0.
  logic [N_DELAY+1:0] ext;
  logic [N_DELAY-1:0] fixed;
  logic [CODE_W-1:0]  cnt;

  assign ext = {1'b0, therm_i, 1'b1};

  // Majority of each tap and its two neighbours removes isolated bubbles.
  always_comb begin
    fixed = '0;
    for (int i = 0; i < int'(N_DELAY); i++) begin
      fixed[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]);
    end
  end

  // Population count of the corrected thermometer.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < int'(N_DELAY); i++) begin
      cnt = cnt + CODE_W'(fixed[i]);
    end
  end

  assign sat_c  = &therm_i;
  assign code_c = sat_c ? CODE_W'(N_DELAY) : cnt;

endmodule

// File: rtl/tdc_therm_decoder.sv
// TDC thermometer decoder: synchronises start and the delay-line snapshot,
// decodes each sample, averages 2^ACC_LOG2 codes and hands the result off
// over valid/ready. Define TDC_MINMAX_EN to add per-batch min/max tracking;
// without it meas_min/meas_max are tied to 0.
module tdc_therm_decoder
  import tdc_pkg::*;
#(
  parameter int unsigned N_DELAY  = TDC_N_DELAY,
  parameter int unsigned CODE_W   = tdc_code_w(N_DELAY),
  parameter int unsigned ACC_LOG2 = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [N_DELAY-1:0] therm_in,
  input  logic               clear,
  output logic               meas_valid,
  input  logic               meas_ready,
  output logic [CODE_W-1:0]  meas_avg,
  output logic [CODE_W-1:0]  meas_last,
  output logic               meas_ovf,
  output logic [7:0]         drop_cnt,
  output logic [CODE_W-1:0]  meas_min,
  output logic [CODE_W-1:0]  meas_max
);

  localparam int unsigned ACC_W  = CODE_W + ACC_LOG2;
  localparam int unsigned CNT_W  = (ACC_LOG2 > 0) ? ACC_LOG2 : 1;
  localparam int unsigned DROP_W = 8;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((1 << ACC_LOG2) - 1);
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  logic                   start_s1_q, start_s2_q, start_prev_q;
  logic [N_DELAY-1:0]     therm_s1_q, therm_s2_q, snap_q;
  logic [CODE_W-1:0]      code_q, code_c;
  logic                   sat_q, sat_c;

  logic [TDC_STATE_W-1:0] state_q, state_d;
  logic [ACC_W-1:0]       acc_q, acc_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;
  logic [DROP_W-1:0]      drop_q, drop_d;
  logic                   valid_q, valid_d;
  logic [CODE_W-1:0]      avg_q, avg_d;
  logic [CODE_W-1:0]      last_q, last_d;

  logic                   edge_c, accum_c, last_c;
  logic [ACC_W-1:0]       sum_c;

  tdc_therm2bin #(
    .N_DELAY (N_DELAY),
    .CODE_W  (CODE_W)
  ) u_therm2bin (
    .therm_i (snap_q),
    .code_c  (code_c),
    .sat_c   (sat_c)
  );

  assign edge_c  = start_s2_q & ~start_prev_q;
  assign accum_c = (state_q == TDC_ACCUM);
  assign last_c  = (cnt_q == CNT_LAST);
  assign sum_c   = acc_q + ACC_W'(code_q);

  // Two-flop synchronisers for the start pad and the delay-line snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_s1_q   <= 1'b0;
      start_s2_q   <= 1'b0;
      start_prev_q <= 1'b0;
      therm_s1_q   <= '0;
      therm_s2_q   <= '0;
    end else begin
      start_s1_q   <= start;
      start_s2_q   <= start_s1_q;
      start_prev_q <= start_s2_q;
      therm_s1_q   <= therm_in;
      therm_s2_q   <= therm_s1_q;
    end
  end

  // Snapshot capture in SAMPLE, registered decode result in DECODE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_q <= '0;
      code_q <= '0;
      sat_q  <= 1'b0;
    end else begin
      if (state_q == TDC_SAMPLE) snap_q <= therm_s2_q;
      if (state_q == TDC_DECODE) begin
        code_q <= code_c;
        sat_q  <= sat_c;
      end
    end
  end

  // FSM state and batch registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TDC_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
      valid_q <= 1'b0;
      avg_q   <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
      valid_q <= valid_d;
      avg_q   <= avg_d;
      last_q  <= last_d;
    end
  end

  // Next-state: sample sequencing, accumulation, handoff, drop counting; clear overrides all.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    drop_d  = drop_q;
    valid_d = valid_q;
    avg_d   = avg_q;
    last_d  = last_q;

    if (edge_c && (state_q != TDC_IDLE) && (drop_q != DROP_MAX)) begin
      drop_d = drop_q + 8'd1;
    end

    case (state_q)
      TDC_IDLE:   if (edge_c) state_d = TDC_SAMPLE;
      TDC_SAMPLE: state_d = TDC_DECODE;
      TDC_DECODE: state_d = TDC_ACCUM;
      TDC_ACCUM: begin
        acc_d = sum_c;
        ovf_d = ovf_q | sat_q;
        if (last_c) begin
          state_d = TDC_HOLD;
          cnt_d   = '0;
          valid_d = 1'b1;
          avg_d   = CODE_W'(sum_c >> ACC_LOG2);
          last_d  = code_q;
        end else begin
          state_d = TDC_IDLE;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      TDC_HOLD: begin
        if (meas_ready) begin
          state_d = TDC_IDLE;
          valid_d = 1'b0;
          acc_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = TDC_IDLE;
    endcase

    if (clear) begin
      state_d = TDC_IDLE;
      valid_d = 1'b0;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      drop_d  = '0;
    end
  end

  assign meas_valid = valid_q;
  assign meas_avg   = avg_q;
  assign meas_last  = last_q;
  assign meas_ovf   = ovf_q;
  assign drop_cnt   = drop_q;

`ifdef TDC_MINMAX_EN
  logic [CODE_W-1:0] bmin_q, bmin_d, bmax_q, bmax_d;
  logic [CODE_W-1:0] omin_q, omin_d, omax_q, omax_d;
  logic [CODE_W-1:0] nmin_c, nmax_c;

  assign nmin_c = (code_q < bmin_q) ? code_q : bmin_q;
  assign nmax_c = (code_q > bmax_q) ? code_q : bmax_q;

  // Per-batch extremes; trackers restart at each batch end or clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bmin_q <= CODE_W'(N_DELAY);
      bmax_q <= '0;
      omin_q <= '0;
      omax_q <= '0;
    end else begin
      bmin_q <= bmin_d;
      bmax_q <= bmax_d;
      omin_q <= omin_d;
      omax_q <= omax_d;
    end
  end

  // Track every accumulated code and publish on entry to HOLD.
  always_comb begin
    bmin_d = bmin_q;
    bmax_d = bmax_q;
    omin_d = omin_q;
    omax_d = omax_q;
    if (clear) begin
      bmin_d = CODE_W'(N_DELAY);
      bmax_d = '0;
    end else if (accum_c) begin
      if (last_c) begin
        omin_d = nmin_c;
        omax_d = nmax_c;
        bmin_d = CODE_W'(N_DELAY);
        bmax_d = '0;
      end else begin
        bmin_d = nmin_c;
        bmax_d = nmax_c;
      end
    end
  end

  assign meas_min = omin_q;
  assign meas_max = omax_q;
`else
  assign meas_min = '0;
  assign meas_max = '0;
`endif

endmodule

// File: tb/tb_tdc_therm_decoder.sv
// Self-checking bench for tdc_therm_decoder (ACC_LOG2=2, batches of 4).
// Expected results come from a spec-level model: majority bubble fix and
// popcount per sample, batch average/last/ovf/min/max computed from a queue.
module tb_tdc_therm_decoder;

  localparam int unsigned N  = 32;
  localparam int unsigned CW = 6;
  localparam int unsigned AL = 2;
  localparam int unsigned NS = 1 << AL;

  logic          clk = 1'b0;
  logic          rst_n, start, clear, meas_ready;
  logic [N-1:0]  therm_in;
  logic          meas_valid, meas_ovf;
  logic [CW-1:0] meas_avg, meas_last, meas_min, meas_max;
  logic [7:0]    drop_cnt;

  always #5 clk = ~clk;

  tdc_therm_decoder #(
    .N_DELAY  (N),
    .CODE_W   (CW),
    .ACC_LOG2 (AL)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .therm_in   (therm_in),
    .clear      (clear),
    .meas_valid (meas_valid),
    .meas_ready (meas_ready),
    .meas_avg   (meas_avg),
    .meas_last  (meas_last),
    .meas_ovf   (meas_ovf),
    .drop_cnt   (drop_cnt),
    .meas_min   (meas_min),
    .meas_max   (meas_max)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int q_codes[$];
  bit m_ovf;
  int exp_drop;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Reference decode: majority over neighbours, edges padded 1 below / 0 above.
  function automatic int ref_code(input logic [N-1:0] t);
    int n = 0;
    int up, dn;
    if (&t) return N;
    for (int i = 0; i < int'(N); i++) begin
      up = (i == 0) ? 1 : int'(t[i-1]);
      dn = (i == int'(N) - 1) ? 0 : int'(t[i+1]);
      if (up + int'(t[i]) + dn >= 2) n++;
    end
    return n;
  endfunction

  function automatic logic [N-1:0] rand_therm();
    int         k = $urandom_range(0, N);
    int         p = $urandom_range(0, N - 1);
    logic [N:0] w;
    logic [N-1:0] t;
    w = (33'd1 << k) - 33'd1;
    t = w[N-1:0];
    if ($urandom_range(0, 1) == 1) t[p] = ~t[p];
    return t;
  endfunction

  task automatic pulse(input logic [N-1:0] t);
    @(negedge clk);
    therm_in = t;
    start    = 1'b1;
    repeat (2) @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic fill(input string tag, input logic [N-1:0] t0, input logic [N-1:0] t1,
                      input logic [N-1:0] t2, input logic [N-1:0] t3);
    logic [N-1:0] ts[4];
    int lat;
    ts = '{t0, t1, t2, t3};
    meas_ready = 1'b0;
    for (int i = 0; i < int'(NS); i++) begin
      pulse(ts[i]);
      q_codes.push_back(ref_code(ts[i]));
      if (&ts[i]) m_ovf = 1'b1;
      if (i < int'(NS) - 1) begin
        repeat (4) @(negedge clk);
        check({tag, "_novalid"}, meas_valid, 0);
      end
    end
    lat = 2;
    while (!meas_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, 6);
  endtask

  task automatic check_result(input string tag);
    int sum = 0;
    int mn = N;
    int mx = 0;
    foreach (q_codes[i]) begin
      sum += q_codes[i];
      if (q_codes[i] < mn) mn = q_codes[i];
      if (q_codes[i] > mx) mx = q_codes[i];
    end
    check({tag, "_valid"}, meas_valid, 1);
    check({tag, "_avg"},   meas_avg,   sum >> AL);
    check({tag, "_last"},  meas_last,  q_codes[$]);
    check({tag, "_ovf"},   meas_ovf,   m_ovf);
    check({tag, "_drop"},  drop_cnt,   exp_drop);
`ifdef TDC_MINMAX_EN
    check({tag, "_min"},   meas_min,   mn);
    check({tag, "_max"},   meas_max,   mx);
`else
    check({tag, "_min"},   meas_min,   0);
    check({tag, "_max"},   meas_max,   0);
`endif
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    meas_ready = 1'b1;
    @(negedge clk);
    meas_ready = 1'b0;
    q_codes.delete();
    m_ovf = 1'b0;
    check({tag, "_hs_valid"}, meas_valid, 0);
    check({tag, "_hs_ovf"},   meas_ovf,   0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, meas_valid, 0);
    check({tag, "_avg"},   meas_avg,   0);
    check({tag, "_last"},  meas_last,  0);
    check({tag, "_ovf"},   meas_ovf,   0);
    check({tag, "_drop"},  drop_cnt,   0);
    check({tag, "_min"},   meas_min,   0);
    check({tag, "_max"},   meas_max,   0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; clear = 1'b0; meas_ready = 1'b0; therm_in = '0;
    m_ovf = 1'b0; exp_drop = 0;
    repeat (3) @(negedge clk);
    check_zero("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Plain 16-tap thermometer.
    fill("t1", 32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_FFFF);
    check_result("t1");
    check("t1_avg_const", meas_avg, 16);
    handshake("t1");

    // Bubble correction and saturation.
    fill("t2", 32'h0000_FF7F, 32'hFFFF_FFFF, 32'h0000_FFFF, 32'h0000_FF7F);
    check_result("t2");
    check("t2_last_const", meas_last, 16);
    check("t2_ovf_const",  meas_ovf,  1);
    handshake("t2");

    // Codes 10,11,11,13.
    fill("t3", 32'h0000_03FF, 32'h0000_07FF, 32'h0000_07FB, 32'h0000_1FFF);
    check_result("t3");
    check("t3_avg_const",  meas_avg,  11);
    check("t3_last_const", meas_last, 13);
    handshake("t3");

    // Back-pressure: three edges in HOLD are dropped, outputs stay put.
    fill("t4", 32'h0003_FFFF, 32'h0000_000F, 32'h00FF_FFFF, 32'h0000_0FFF);
    check_result("t4a");
    for (int k = 0; k < 3; k++) begin
      pulse(32'h0000_0001);
      repeat (4) @(negedge clk);
    end
    exp_drop += 3;
    check_result("t4b");
    check("t4_drop_const", drop_cnt, 3);
    handshake("t4");

    // Clear after two of four samples.
    pulse(32'hFFFF_FFFF);
    repeat (4) @(negedge clk);
    pulse(32'h0000_000F);
    repeat (4) @(negedge clk);
    check("t5_partial_novalid", meas_valid, 0);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    exp_drop = 0;
    check("t5_clr_drop",  drop_cnt,   0);
    check("t5_clr_ovf",   meas_ovf,   0);
    check("t5_clr_valid", meas_valid, 0);
    fill("t5", 32'h0000_00FF, 32'h0000_00FF, 32'h0000_0FFF, 32'h0000_0FFF);
    check_result("t5");
    check("t5_avg_const", meas_avg, 10);

    // One drop in HOLD, then an edge coinciding with the handshake.
    pulse(32'h0000_0003);
    repeat (4) @(negedge clk);
    exp_drop = 1;
    check("t5_hold_drop", drop_cnt, exp_drop);
    @(negedge clk);
    therm_in = 32'h0000_0007;
    start    = 1'b1;
    repeat (2) @(negedge clk);
    start      = 1'b0;
    meas_ready = 1'b1;
    @(negedge clk);
    meas_ready = 1'b0;
    q_codes.delete();
    m_ovf = 1'b0;
    exp_drop = 2;
    check("hsedge_valid", meas_valid, 0);
    check("hsedge_drop",  drop_cnt,   exp_drop);
    repeat (4) @(negedge clk);
    fill("hsedge", 32'h0000_001F, 32'h0000_003F, 32'h0000_007F, 32'h0000_00FF);
    check_result("hsedge");
    handshake("hsedge");

    // Asynchronous reset while the FSM is in DECODE.
    pulse(32'h0000_00FF);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("t6");
    @(negedge clk);
    rst_n = 1'b1;
    q_codes.delete();
    m_ovf = 1'b0;
    exp_drop = 0;
    fill("t6", 32'h0FFF_FFFF, 32'h0000_FFFF, 32'h0000_0000, 32'h7FFF_FFFF);
    check_result("t6");
    handshake("t6");

    // Randomised batches.
    for (int b = 0; b < 8; b++) begin
      fill($sformatf("rnd%0d", b), rand_therm(), rand_therm(), rand_therm(), rand_therm());
      check_result($sformatf("rnd%0d", b));
      handshake($sformatf("rnd%0d", b));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
